// File: rtl/seq_rotate_left_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_rotate_left_pkg
//  Brief    : Shared types and default sizes for the sequential left rotator.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_rotate_left_pkg;

    // Three-state controller: wait for start, rotate bit by bit, report done.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_AMT_W = 2;

endpackage : seq_rotate_left_pkg
`default_nettype wire

// File: rtl/seq_rotate_left_rot_step.sv
`default_nettype none
// ============================================================================
//  Module   : rot_step
//  Brief    : Combinational one-bit left rotate (MSB wraps into bit 0).
//  Revision : 1.0 - initial release
// ============================================================================
module rot_step
    import seq_rotate_left_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    // Shift everything up one place and feed the old MSB back into bit 0.
    always_comb begin
        data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
    end

endmodule : rot_step
`default_nettype wire

// File: rtl/seq_rotate_left.sv
`default_nettype none
// ============================================================================
//  Module   : seq_rotate_left
//  Brief    : Sequential left rotator. Rotates A left by S one bit per clock,
//             then publishes the result on RTO with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_rotate_left
    import seq_rotate_left_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             rst,     // asynchronous, active-low
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [AMT_W-1:0] S,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] RTO
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q,  work_d;
    logic [AMT_W-1:0]  cnt_q,   cnt_d;
    logic [WIDTH-1:0]  rto_q,   rto_d;
    logic [WIDTH-1:0]  work_rot;

    rot_step #(
        .WIDTH (WIDTH)
    ) u_rot_step (
        .data_i (work_q),
        .data_o (work_rot)
    );

    // All state lives here; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            rto_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            rto_q   <= rto_d;
        end
    end

    // Next-state decode: a zero count ends SHIFT, so the counter never wraps.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        rto_d   = rto_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = A;
                    cnt_d   = S;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = work_rot;
                    cnt_d  = cnt_q - AMT_W'(1);
                end else begin
                    rto_d   = work_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = (state_q == SHIFT) || (state_q == DONE);
        done = (state_q == DONE);
        RTO  = rto_q;
    end

endmodule : seq_rotate_left
`default_nettype wire

// File: tb/tb_seq_rotate_left.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_rotate_left
//  Brief    : Directed self-checking bench for seq_rotate_left.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_rotate_left;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [1:0] S;
    logic       busy;
    logic       done;
    logic [3:0] RTO;

    int errs   = 0;
    int checks = 0;

    seq_rotate_left #(
        .WIDTH (4),
        .AMT_W (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .S     (S),
        .busy  (busy),
        .done  (done),
        .RTO   (RTO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Hand-computed right rotate used to build exhaustive stimulus.
    function automatic logic [3:0] ror4(input logic [3:0] v, input logic [1:0] s);
        logic [7:0] d;
        d = {v, v} >> s;
        return d[3:0];
    endfunction

    // One full operation: wait for IDLE, pulse start, count edges to done.
    task automatic run_op(input logic [3:0] a, input logic [1:0] s,
                          input logic [3:0] exp, input bit inject);
        int  n;
        bit  seen;
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk); #1; n++;
        end
        A = a; S = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = ~a; S = ~s;              // in-flight result must not follow inputs
        chk("busy_after_accept", busy, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            if (inject && n == 1) begin
                start = 1'b1; A = 4'hF; S = 2'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1; n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 1);
        chk("latency", n, s + 1);
        chk("rto", RTO, exp);
        chk("busy_in_done", busy, 1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; A = 4'h0; S = 2'd0;
        #1;
        chk("rst_rto", RTO, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Basic operations
        run_op(4'b1011, 2'd1, 4'b0111, 1'b0);
        run_op(4'b1000, 2'd3, 4'b0100, 1'b1);   // mid-SHIFT start ignored
        @(posedge clk); #1;
        chk("no_queue_idle", busy, 0);
        @(posedge clk); #1;
        chk("no_queue_idle2", busy, 0);
        chk("rto_held", RTO, 4'b0100);
        run_op(4'b0110, 2'd0, 4'b0110, 1'b0);

        // Exhaustive inverse check, issued back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int s = 0; s < 4; s++) begin
                run_op(ror4(4'(a), 2'(s)), 2'(s), 4'(a), 1'b0);
            end
        end

        // Reset in the middle of SHIFT
        @(posedge clk); #1;
        A = 4'b1011; S = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_rto", RTO, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", done, 0);
        end
        @(negedge clk) rst = 1'b1;
        #1;
        chk("release_busy", busy, 0);
        run_op(4'b0001, 2'd2, 4'b0100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_rotate_left
`default_nettype wire
